// File: rtl/vga_pkg.sv
// Shared constants and helpers for the VGA timing generator.
// Holds sync polarity names, mode presets and the tile counter width helpers.
package vga_pkg;

    // Active level of a sync pulse.
    localparam logic SYNC_ACTIVE_LOW  = 1'b0;
    localparam logic SYNC_ACTIVE_HIGH = 1'b1;

    // Timing of one axis: visible span, porches, sync width and sync level.
    typedef struct packed {
        int   active;
        int   fporch;
        int   sync;
        int   bporch;
        logic pol;
    } axis_timing_t;

    // 1024x768@60 CVT, 64 MHz pixel clock (1328 x 798 total).
    localparam axis_timing_t XGA60_H = '{active: 1024, fporch: 48, sync: 104, bporch: 152,
                                         pol: SYNC_ACTIVE_LOW};
    localparam axis_timing_t XGA60_V = '{active: 768, fporch: 3, sync: 4, bporch: 23,
                                         pol: SYNC_ACTIVE_HIGH};

    // 640x480@60, 25.175 MHz pixel clock (800 x 525 total).
    localparam axis_timing_t VGA60_H = '{active: 640, fporch: 16, sync: 96, bporch: 48,
                                         pol: SYNC_ACTIVE_LOW};
    localparam axis_timing_t VGA60_V = '{active: 480, fporch: 10, sync: 2, bporch: 33,
                                         pol: SYNC_ACTIVE_LOW};

    // Total span of an axis.
    function automatic int axis_total(input axis_timing_t t);
        return t.active + t.fporch + t.sync + t.bporch;
    endfunction

    // Bits for a tile index: ceil(log2(ceil(total/tile)+1)). The last tile of a
    // line or frame may be partial, so the count rounds up.
    function automatic int tile_width(input int total, input int tile);
        int n;
        n = (total + tile - 1) / tile;
        return $clog2(n + 1);
    endfunction

    // Bits for an offset inside a tile (0 .. tile-1), never narrower than 1.
    function automatic int sub_width(input int tile);
        return (tile > 1) ? $clog2(tile) : 1;
    endfunction

endpackage

// File: rtl/vga_axis_counter.sv
// One beam axis: linear position plus tile index and offset within the tile.
// The horizontal and vertical axes of vga_timing_gen are both built from this.
module vga_axis_counter
    import vga_pkg::*;
#(
    parameter int TOTAL = 1328,
    parameter int TILE  = 32,
    parameter int W     = 11,
    parameter int TW    = tile_width(TOTAL, TILE),
    parameter int SW    = sub_width(TILE)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          step_i,
    output logic [W-1:0]  pos_o,
    output logic [W-1:0]  pos_nxt_o,
    output logic [TW-1:0] tile_o,
    output logic [SW-1:0] sub_o,
    output logic          wrap_o
);

    localparam logic [W-1:0]  POS_LAST = W'(TOTAL - 1);
    localparam logic [SW-1:0] SUB_LAST = SW'(TILE - 1);

    logic [W-1:0]  pos_q,  pos_d;
    logic [TW-1:0] tile_q, tile_d;
    logic [SW-1:0] sub_q,  sub_d;

    // Terminal count: the next step returns the whole axis to 0.
    assign wrap_o = (pos_q == POS_LAST);

    // Next position; a wrap clears the tile counters even mid-tile.
    always_comb begin
        pos_d  = pos_q;
        tile_d = tile_q;
        sub_d  = sub_q;
        if (step_i) begin
            if (wrap_o) begin
                pos_d  = '0;
                tile_d = '0;
                sub_d  = '0;
            end else begin
                pos_d = pos_q + 1'b1;
                if (sub_q == SUB_LAST) begin
                    sub_d  = '0;
                    tile_d = tile_q + 1'b1;
                end else begin
                    sub_d = sub_q + 1'b1;
                end
            end
        end
    end

    // Axis state registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            pos_q  <= '0;
            tile_q <= '0;
            sub_q  <= '0;
        end else begin
            pos_q  <= pos_d;
            tile_q <= tile_d;
            sub_q  <= sub_d;
        end
    end

    assign pos_o     = pos_q;
    assign pos_nxt_o = pos_d;
    assign tile_o    = tile_q;
    assign sub_o     = sub_q;

endmodule

// File: rtl/vga_timing_gen.sv
// Parametrised VGA timing generator: linear and tiled beam coordinates, sync,
// blank and line/frame strobes, advancing on cycles with pix_en high.
// Optional feature macro: VGA_TIMING_IRQ_EN builds the scanline-compare
// interrupt (line_irq); without it line_irq is constant 0.
// Every output is a register loaded from the counters' next position, so
// levels and strobes always describe the pixel currently shown on x/y.
module vga_timing_gen
    import vga_pkg::*;
#(
    parameter int   H_ACTIVE   = 1024,
    parameter int   H_FPORCH   = 48,
    parameter int   H_SYNC     = 104,
    parameter int   H_BPORCH   = 152,
    parameter int   V_ACTIVE   = 768,
    parameter int   V_FPORCH   = 3,
    parameter int   V_SYNC     = 4,
    parameter int   V_BPORCH   = 23,
    parameter logic H_SYNC_POL = SYNC_ACTIVE_LOW,
    parameter logic V_SYNC_POL = SYNC_ACTIVE_HIGH,
    parameter int   TILE_W     = 32,
    parameter int   TILE_H     = 48,
    parameter int   XW         = 11,
    parameter int   YW         = 10,
    localparam int  H_TOTAL    = H_ACTIVE + H_FPORCH + H_SYNC + H_BPORCH,
    localparam int  V_TOTAL    = V_ACTIVE + V_FPORCH + V_SYNC + V_BPORCH,
    localparam int  TXW        = tile_width(H_TOTAL, TILE_W),
    localparam int  SXW        = sub_width(TILE_W),
    localparam int  TYW        = tile_width(V_TOTAL, TILE_H),
    localparam int  SYW        = sub_width(TILE_H)
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           pix_en,
    input  logic [YW-1:0]  irq_line,
    output logic [XW-1:0]  x,
    output logic [YW-1:0]  y,
    output logic [TXW-1:0] tile_x,
    output logic [SXW-1:0] sub_x,
    output logic [TYW-1:0] tile_y,
    output logic [SYW-1:0] sub_y,
    output logic           hsync,
    output logic           vsync,
    output logic           blank,
    output logic           line_start,
    output logic           frame_start,
    output logic           line_irq
);

    // Reject widths that cannot hold the last position of an axis.
    if (H_TOTAL > (1 << XW)) begin : g_bad_xw
        $error("vga_timing_gen: XW=%0d cannot hold H_TOTAL-1=%0d", XW, H_TOTAL - 1);
    end
    if (V_TOTAL > (1 << YW)) begin : g_bad_yw
        $error("vga_timing_gen: YW=%0d cannot hold V_TOTAL-1=%0d", YW, V_TOTAL - 1);
    end
    if (TILE_W < 1 || TILE_H < 1) begin : g_bad_tile
        $error("vga_timing_gen: tile sizes must be at least 1");
    end

    // Compare limits carry one extra bit so an interval ending at 2**XW still fits.
    localparam logic [XW:0] H_ACT_LIM = (XW+1)'(H_ACTIVE);
    localparam logic [XW:0] HS_BEG    = (XW+1)'(H_ACTIVE + H_FPORCH);
    localparam logic [XW:0] HS_END    = (XW+1)'(H_ACTIVE + H_FPORCH + H_SYNC);
    localparam logic [YW:0] V_ACT_LIM = (YW+1)'(V_ACTIVE);
    localparam logic [YW:0] VS_BEG    = (YW+1)'(V_ACTIVE + V_FPORCH);
    localparam logic [YW:0] VS_END    = (YW+1)'(V_ACTIVE + V_FPORCH + V_SYNC);

    logic [XW-1:0] h_nxt;
    logic [YW-1:0] v_nxt;
    logic          h_wrap, v_wrap, v_step;

    // The vertical axis moves once per completed line.
    assign v_step = pix_en && h_wrap;

    vga_axis_counter #(
        .TOTAL (H_TOTAL),
        .TILE  (TILE_W),
        .W     (XW),
        .TW    (TXW),
        .SW    (SXW)
    ) u_h_cnt (
        .clk       (clk),
        .rst       (rst),
        .step_i    (pix_en),
        .pos_o     (x),
        .pos_nxt_o (h_nxt),
        .tile_o    (tile_x),
        .sub_o     (sub_x),
        .wrap_o    (h_wrap)
    );

    vga_axis_counter #(
        .TOTAL (V_TOTAL),
        .TILE  (TILE_H),
        .W     (YW),
        .TW    (TYW),
        .SW    (SYW)
    ) u_v_cnt (
        .clk       (clk),
        .rst       (rst),
        .step_i    (v_step),
        .pos_o     (y),
        .pos_nxt_o (v_nxt),
        .tile_o    (tile_y),
        .sub_o     (sub_y),
        .wrap_o    (v_wrap)
    );

    logic hsync_q, hsync_d;
    logic vsync_q, vsync_d;
    logic blank_q, blank_d;
    logic line_start_q, line_start_d;
    logic frame_start_q, frame_start_d;

    // Levels for the pixel about to be shown; strobes only on an actual step onto x=0.
    always_comb begin
        hsync_d       = ~H_SYNC_POL;
        vsync_d       = ~V_SYNC_POL;
        blank_d       = 1'b1;
        line_start_d  = 1'b0;
        frame_start_d = 1'b0;
        if (({1'b0, h_nxt} >= HS_BEG) && ({1'b0, h_nxt} < HS_END)) begin
            hsync_d = H_SYNC_POL;
        end
        if (({1'b0, v_nxt} >= VS_BEG) && ({1'b0, v_nxt} < VS_END)) begin
            vsync_d = V_SYNC_POL;
        end
        if (({1'b0, h_nxt} < H_ACT_LIM) && ({1'b0, v_nxt} < V_ACT_LIM)) begin
            blank_d = 1'b0;
        end
        if (pix_en && h_wrap) begin
            line_start_d  = 1'b1;
            frame_start_d = v_wrap;
        end
    end

    // Output registers; reset shows pixel (0,0) with no strobe.
    always_ff @(posedge clk) begin
        if (rst) begin
            hsync_q       <= ~H_SYNC_POL;
            vsync_q       <= ~V_SYNC_POL;
            blank_q       <= 1'b0;
            line_start_q  <= 1'b0;
            frame_start_q <= 1'b0;
        end else begin
            hsync_q       <= hsync_d;
            vsync_q       <= vsync_d;
            blank_q       <= blank_d;
            line_start_q  <= line_start_d;
            frame_start_q <= frame_start_d;
        end
    end

    assign hsync       = hsync_q;
    assign vsync       = vsync_q;
    assign blank       = blank_q;
    assign line_start  = line_start_q;
    assign frame_start = frame_start_q;

`ifdef VGA_TIMING_IRQ_EN
    logic line_irq_q, line_irq_d;

    // Live compare against the line being entered; values >= V_TOTAL never match.
    always_comb begin
        line_irq_d = line_start_d && (v_nxt == irq_line);
    end

    // Interrupt strobe register.
    always_ff @(posedge clk) begin
        if (rst) begin
            line_irq_q <= 1'b0;
        end else begin
            line_irq_q <= line_irq_d;
        end
    end

    assign line_irq = line_irq_q;
`else
    logic unused_irq_line;
    assign unused_irq_line = ^irq_line;
    assign line_irq        = 1'b0;
`endif

endmodule

// File: tb/tb_vga_timing_gen.sv
// Self-checking bench for vga_timing_gen on a reduced mode (58 x 29, 7x6 tiles)
// so several complete frames fit in a short run. The reference model derives
// every output from the number of pixels advanced since reset.
module tb_vga_timing_gen;
    import vga_pkg::*;

    localparam int   HA = 40, HF = 4, HS = 6, HB = 8;
    localparam int   VA = 20, VF = 2, VS = 3, VB = 4;
    localparam int   HT = HA + HF + HS + HB;
    localparam int   VT = VA + VF + VS + VB;
    localparam int   FR = HT * VT;
    localparam logic HP = 1'b0, VP = 1'b1;
    localparam int   TW = 7, TH = 6, XW = 6, YW = 5;
    localparam int   TXW = tile_width(HT, TW), SXW = sub_width(TW);
    localparam int   TYW = tile_width(VT, TH), SYW = sub_width(TH);
`ifdef VGA_TIMING_IRQ_EN
    localparam bit IRQ_ON = 1'b1;
`else
    localparam bit IRQ_ON = 1'b0;
`endif

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic           pix_en = 1'b0;
    logic [YW-1:0]  irq_line = '0;
    logic [XW-1:0]  x;
    logic [YW-1:0]  y;
    logic [TXW-1:0] tile_x;
    logic [SXW-1:0] sub_x;
    logic [TYW-1:0] tile_y;
    logic [SYW-1:0] sub_y;
    logic           hsync, vsync, blank, line_start, frame_start, line_irq;

    int checks = 0;
    int errors = 0;
    int n = 0;       // pixels advanced since the last reset
    bit adv = 1'b0;  // previous edge advanced the beam

    vga_timing_gen #(
        .H_ACTIVE(HA), .H_FPORCH(HF), .H_SYNC(HS), .H_BPORCH(HB),
        .V_ACTIVE(VA), .V_FPORCH(VF), .V_SYNC(VS), .V_BPORCH(VB),
        .H_SYNC_POL(HP), .V_SYNC_POL(VP),
        .TILE_W(TW), .TILE_H(TH), .XW(XW), .YW(YW)
    ) dut (
        .clk(clk), .rst(rst), .pix_en(pix_en), .irq_line(irq_line),
        .x(x), .y(y), .tile_x(tile_x), .sub_x(sub_x), .tile_y(tile_y), .sub_y(sub_y),
        .hsync(hsync), .vsync(vsync), .blank(blank),
        .line_start(line_start), .frame_start(frame_start), .line_irq(line_irq)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [XW-1:0]  x;
        logic [YW-1:0]  y;
        logic [TXW-1:0] tx;
        logic [SXW-1:0] sx;
        logic [TYW-1:0] ty;
        logic [SYW-1:0] sy;
        logic hs, vs, bl, ls, fs, li;
    } exp_t;

    // Expected outputs from the pixel count: plain division/modulo of the frame raster.
    function automatic exp_t model();
        exp_t e;
        int px, py;
        px   = n % HT;
        py   = (n / HT) % VT;
        e.x  = XW'(px);
        e.y  = YW'(py);
        e.tx = TXW'(px / TW);
        e.sx = SXW'(px % TW);
        e.ty = TYW'(py / TH);
        e.sy = SYW'(py % TH);
        e.hs = (px >= HA + HF && px < HA + HF + HS) ? HP : ~HP;
        e.vs = (py >= VA + VF && py < VA + VF + VS) ? VP : ~VP;
        e.bl = !(px < HA && py < VA);
        e.ls = adv && (px == 0);
        e.fs = e.ls && (py == 0);
        e.li = IRQ_ON && e.ls && (py == int'(irq_line));
        return e;
    endfunction

    // Drive one cycle of inputs, let the edge pass, then advance the model.
    task automatic tick(input bit en, input bit r);
        pix_en = en;
        rst    = r;
        @(posedge clk);
        #1;
        if (r) begin
            n   = 0;
            adv = 1'b0;
        end else begin
            adv = en;
            if (en) n++;
        end
    endtask

    task automatic test_reset();
        tick(1'b1, 1'b1);
        tick(1'b1, 1'b1);
        checks++;
        if ({x, y, tile_x, sub_x, tile_y, sub_y} !== '0) begin
            errors++;
            $display("FAIL reset_coords: got x=%0d y=%0d tx=%0d sx=%0d ty=%0d sy=%0d exp all 0",
                     x, y, tile_x, sub_x, tile_y, sub_y);
        end
        checks++;
        if ({hsync, vsync, blank, line_start, frame_start, line_irq} !== {~HP, ~VP, 4'b0000}) begin
            errors++;
            $display("FAIL reset_levels: got hs=%b vs=%b bl=%b ls=%b fs=%b li=%b exp hs=%b vs=%b rest 0",
                     hsync, vsync, blank, line_start, frame_start, line_irq, ~HP, ~VP);
        end
    endtask

    // First line after reset: x sweeps the whole line and wraps, y steps once.
    task automatic test_first_line();
        exp_t e;
        int ls_cnt = 0, fs_cnt = 0;
        for (int i = 0; i < HT; i++) begin
            tick(1'b1, 1'b0);
            e = model();
            ls_cnt += int'(line_start);
            fs_cnt += int'(frame_start);
            checks++;
            if (x !== e.x || y !== e.y || line_start !== e.ls || frame_start !== e.fs) begin
                errors++;
                $display("FAIL first_line: got x=%0d y=%0d ls=%b fs=%b exp x=%0d y=%0d ls=%b fs=%b",
                         x, y, line_start, frame_start, e.x, e.y, e.ls, e.fs);
            end
        end
        checks++;
        if (x !== '0 || y !== YW'(1) || ls_cnt != 1 || fs_cnt != 0) begin
            errors++;
            $display("FAIL first_line_end: got x=%0d y=%0d ls_cnt=%0d fs_cnt=%0d exp 0 1 1 0",
                     x, y, ls_cnt, fs_cnt);
        end
    endtask

    // One full frame at full rate: sync, blank and tile coordinates every pixel.
    task automatic test_frame_levels();
        exp_t e;
        int fs_cnt = 0, hs_cnt = 0;
        for (int i = 0; i < FR; i++) begin
            tick(1'b1, 1'b0);
            e = model();
            fs_cnt += int'(frame_start);
            hs_cnt += int'(hsync == HP);
            checks++;
            if ({hsync, vsync, blank} !== {e.hs, e.vs, e.bl}) begin
                errors++;
                $display("FAIL levels: at x=%0d y=%0d got hs=%b vs=%b bl=%b exp %b %b %b",
                         e.x, e.y, hsync, vsync, blank, e.hs, e.vs, e.bl);
            end
            checks++;
            if ({tile_x, sub_x, tile_y, sub_y} !== {e.tx, e.sx, e.ty, e.sy}) begin
                errors++;
                $display("FAIL tiles: at x=%0d y=%0d got tx=%0d sx=%0d ty=%0d sy=%0d exp %0d %0d %0d %0d",
                         e.x, e.y, tile_x, sub_x, tile_y, sub_y, e.tx, e.sx, e.ty, e.sy);
            end
        end
        checks++;
        if (fs_cnt != 1 || hs_cnt != HS * VT) begin
            errors++;
            $display("FAIL frame_counts: got fs=%0d hsync_active=%0d exp 1 %0d", fs_cnt, hs_cnt, HS * VT);
        end
    endtask

    // Half-rate pixel enable: every pixel held two cycles, strobes one cycle wide.
    task automatic test_toggle();
        exp_t e;
        int last = -1, gaps = 0;
        for (int i = 0; i < 4 * FR; i++) begin
            tick((i % 2) == 0, 1'b0);
            e = model();
            checks++;
            if (x !== e.x || y !== e.y || line_start !== e.ls || frame_start !== e.fs) begin
                errors++;
                $display("FAIL toggle: got x=%0d y=%0d ls=%b fs=%b exp x=%0d y=%0d ls=%b fs=%b",
                         x, y, line_start, frame_start, e.x, e.y, e.ls, e.fs);
            end
            if (frame_start === 1'b1) begin
                if (last >= 0) begin
                    gaps++;
                    checks++;
                    if (i - last != 2 * FR) begin
                        errors++;
                        $display("FAIL toggle_frame_len: got %0d cycles exp %0d", i - last, 2 * FR);
                    end
                end
                last = i;
            end
        end
        checks++;
        if (gaps < 1) begin
            errors++;
            $display("FAIL toggle_frames_seen: got %0d frame intervals exp at least 1", gaps);
        end
    endtask

    // Scanline interrupt at an in-range line and at an out-of-range line.
    task automatic test_irq();
        exp_t e;
        int cnt;
        for (int k = 0; k < 2; k++) begin
            irq_line = (k == 0) ? YW'(10) : YW'(30);
            cnt = 0;
            for (int i = 0; i < FR; i++) begin
                tick(1'b1, 1'b0);
                e = model();
                cnt += int'(line_irq);
                checks++;
                if (line_irq !== e.li) begin
                    errors++;
                    $display("FAIL irq_strobe: irq_line=%0d at x=%0d y=%0d got %b exp %b",
                             irq_line, e.x, e.y, line_irq, e.li);
                end
            end
            checks++;
            if (cnt != ((IRQ_ON && k == 0) ? 1 : 0)) begin
                errors++;
                $display("FAIL irq_count: irq_line=%0d got %0d exp %0d",
                         irq_line, cnt, (IRQ_ON && k == 0) ? 1 : 0);
            end
        end
    endtask

    // Random pixel enable and live irq_line changes against the full model.
    task automatic test_random();
        exp_t e;
        for (int i = 0; i < 3 * FR; i++) begin
            if (i % 37 == 0) irq_line = YW'($urandom_range(0, 31));
            tick($urandom_range(0, 3) != 0, 1'b0);
            e = model();
            checks++;
            if ({x, y, tile_x, sub_x, tile_y, sub_y} !== {e.x, e.y, e.tx, e.sx, e.ty, e.sy}) begin
                errors++;
                $display("FAIL rand_coords: got x=%0d y=%0d tx=%0d sx=%0d ty=%0d sy=%0d exp %0d %0d %0d %0d %0d %0d",
                         x, y, tile_x, sub_x, tile_y, sub_y, e.x, e.y, e.tx, e.sx, e.ty, e.sy);
            end
            checks++;
            if ({hsync, vsync, blank, line_start, frame_start, line_irq} !==
                {e.hs, e.vs, e.bl, e.ls, e.fs, e.li}) begin
                errors++;
                $display("FAIL rand_flags: at x=%0d y=%0d got hs%b vs%b bl%b ls%b fs%b li%b exp %b%b%b%b%b%b",
                         e.x, e.y, hsync, vsync, blank, line_start, frame_start, line_irq,
                         e.hs, e.vs, e.bl, e.ls, e.fs, e.li);
            end
        end
    endtask

    // Reset mid-frame at (30,15): immediate reset values, next frame_start one frame later.
    task automatic test_mid_reset();
        exp_t e;
        int guard = 0;
        irq_line = '0;
        e = model();
        while (!(e.x == XW'(30) && e.y == YW'(15)) && guard < 2 * FR) begin
            tick(1'b1, 1'b0);
            e = model();
            guard++;
        end
        checks++;
        if (x !== XW'(30) || y !== YW'(15)) begin
            errors++;
            $display("FAIL mid_reset_reach: got x=%0d y=%0d exp 30 15", x, y);
        end
        tick(1'b1, 1'b1);
        checks++;
        if ({x, y, tile_x, sub_x, tile_y, sub_y, hsync, vsync, blank, line_start, frame_start, line_irq}
            !== {{(XW + YW + TXW + SXW + TYW + SYW){1'b0}}, ~HP, ~VP, 4'b0000}) begin
            errors++;
            $display("FAIL mid_reset_values: got x=%0d y=%0d tx=%0d sx=%0d ty=%0d sy=%0d hs%b vs%b bl%b ls%b fs%b li%b",
                     x, y, tile_x, sub_x, tile_y, sub_y, hsync, vsync, blank, line_start, frame_start, line_irq);
        end
        for (int i = 0; i < FR; i++) begin
            tick(1'b1, 1'b0);
            checks++;
            if (frame_start !== (i == FR - 1)) begin
                errors++;
                $display("FAIL mid_reset_frame_start: cycle %0d got %b exp %b", i, frame_start, i == FR - 1);
            end
        end
        checks++;
        if (x !== '0 || y !== '0) begin
            errors++;
            $display("FAIL mid_reset_wrap: got x=%0d y=%0d exp 0 0", x, y);
        end
    endtask

    initial begin
        test_reset();
        test_first_line();
        test_frame_levels();
        test_toggle();
        test_irq();
        test_random();
        test_mid_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/vga_timing_gen.md
# vga_timing_gen

Parametrised successor to the team's fixed 1024x768 VGA timing generator. Produces linear and tiled (coarse/fine) beam coordinates, sync, blank, line/frame start strobes and an optional scanline-compare interrupt. Mode timing, sync polarities and tile geometry are parameters, and a pixel-enable input supports divided pixel clocks. It sits between the pixel clock domain and the peripheral's framebuffer/pattern logic.

## Interface

- H_ACTIVE, 1024, visible pixels per line
- H_FPORCH / H_SYNC / H_BPORCH, 48 / 104 / 152, horizontal porch and sync widths in pixels
- V_ACTIVE, 768, visible lines
- V_FPORCH / V_SYNC / V_BPORCH, 3 / 4 / 23, vertical porch and sync widths in lines
- H_SYNC_POL / V_SYNC_POL, 0 / 1, active level of hsync / vsync
- TILE_W / TILE_H, 32 / 48, tile size in pixels / lines; need not be a power of two
- XW / YW, 11 / 10, widths of x / y; must hold H_TOTAL-1 / V_TOTAL-1 (elaboration error otherwise)
- clk  in  1  pixel clock
- rst  in  1  synchronous reset, active-high
- pix_en  in  1  advance one pixel this cycle
- irq_line  in  YW  line-compare value
- x, y  out  XW, YW  linear beam position
- tile_x, sub_x, tile_y, sub_y  out  derived widths  tiled position
- hsync, vsync  out  1  sync at configured polarity
- blank  out  1  high outside the active area
- line_start, frame_start, line_irq  out  1  single-cycle strobes

## Operation

- Totals: H_TOTAL = H_ACTIVE + H_FPORCH + H_SYNC + H_BPORCH; V_TOTAL is the vertical equivalent. Defaults give 1328 x 798.
- The position advances only on cycles where pix_en=1. Otherwise all coordinate and level outputs hold.
- Horizontal counting:
  - x counts 0 to H_TOTAL-1, then wraps to 0.
  - sub_x counts 0 to TILE_W-1; on its rollover, tile_x increments.
  - An x wrap forces sub_x and tile_x to 0 regardless of tile phase, so a partial tile at line end is allowed.
- Vertical counting: y, sub_y and tile_y advance only on an x wrap, using the same scheme with TILE_H and V_TOTAL. A y wrap starts a new frame.
- Tile counters keep running through blanking. A pixel is in the active area iff x<H_ACTIVE and y<V_ACTIVE.
- Level outputs:
  - hsync = H_SYNC_POL when H_ACTIVE+H_FPORCH <= x < H_ACTIVE+H_FPORCH+H_SYNC; otherwise it is the inverse.
  - vsync follows the same rule on y.
  - blank = !(x<H_ACTIVE && y<V_ACTIVE).
- Strobes:
  - line_start is high for exactly one clk cycle: the first cycle in which the outputs show x=0.
  - frame_start is the same, but requires x=0 and y=0.
  - line_irq is the same as line_start, qualified by y==irq_line.
  - irq_line >= V_TOTAL never fires. irq_line is compared live, with no latching.

## Timing

- All outputs are registered and mutually aligned: sync, blank, tile and strobe outputs always describe the pixel currently on x/y. There is no skew between them.
- Reset values: all coordinates 0; hsync=!H_SYNC_POL; vsync=!V_SYNC_POL; blank=0; all strobes 0.
- Reset does not fire frame_start. The first frame_start occurs after one full frame.
- Reset mid-frame returns all outputs to their reset values on the next clk edge.
- With pix_en held high, a frame is H_TOTAL*V_TOTAL cycles (1,059,744 at defaults).
- With pix_en low, the counters freeze and strobes drop to 0. A strobe is never repeated for a held pixel.

## Configuration

- VGA_TIMING_IRQ_EN defined: the irq_line comparator and the line_irq register are built.
- Not defined: line_irq is tied to 0, irq_line is ignored, and no compare logic is synthesised.

## Structure

- vga_pkg holds:
  - polarity constants SYNC_ACTIVE_LOW / SYNC_ACTIVE_HIGH;
  - mode preset localparams for 1024x768@60 CVT (64 MHz) and 640x480@60;
  - a constant function computing tile counter widths ceil(log2(ceil(TOTAL/TILE)+1)).
- Sub-module vga_axis_counter (parameters TOTAL, TILE, W) is instantiated twice:
  - horizontal: step = pix_en;
  - vertical: step = pix_en && horizontal wrap.
  - It outputs pos, tile and sub, plus a wrap flag.

## Test plan

- Reset with pix_en=1 for 1328 cycles: x runs 0 to 1327 then 0. y goes 0 to 1 on that wrap. line_start fires and frame_start stays 0.
- Default mode: hsync is low exactly for x=1072..1175. vsync is high exactly for y=771..774. blank rises at x=1024 and at y=768.
- Tiling with TILE_W=32, TILE_H=48: at x=1023 tile_x=31 and sub_x=31. At x=1327 tile_x=41 and sub_x=15, then both return to 0. At y=768 tile_y=16 and sub_y=0.
- pix_en toggled 1/0 each cycle: each pixel is held 2 cycles, the frame takes 2,119,488 cycles, and each strobe is one cycle wide.
- irq_line=100 with IRQ enabled: line_irq fires once per frame, aligned with x=0, y=100. irq_line=900 never fires. With the macro off, line_irq is always 0.
- rst asserted at x=500, y=300: the next cycle shows all outputs at reset values. No frame_start fires until a full frame later.
